// File: rtl/fifo_pkg.sv
// Shared FIFO pointer types and helpers, used by the write-side and read-side controllers.
package fifo_pkg;

  localparam int SIZE  = 4;
  localparam int DEPTH = 2 ** SIZE;

  typedef logic [SIZE:0] ptr_t;

  // The extra wrap bit lets a full FIFO (DEPTH entries) be told apart from an empty one.
  function automatic ptr_t occupancy(ptr_t w, ptr_t r);
    return w - r;
  endfunction

  function automatic logic is_full(ptr_t w, ptr_t r);
    return (w[SIZE-1:0] == r[SIZE-1:0]) && (w[SIZE] != r[SIZE]);
  endfunction

endpackage

// File: rtl/fifo_write_ctrl_if.sv
// Producer-side bus of the FIFO write controller.
interface fifo_write_ctrl_if
  import fifo_pkg::*;
#(
  parameter int SIZE = fifo_pkg::SIZE
);

  logic            w_en;
  logic            clr_ovf;
  logic [SIZE:0]   r_ptr_ext;
  logic [SIZE:0]   w_ptr_ext;
  logic [SIZE-1:0] w_pointer;
  logic            mem_we;
  logic            full;
  logic            almost_full;
  logic            overflow;

  modport master (
    output w_en, clr_ovf, r_ptr_ext,
    input  w_ptr_ext, w_pointer, mem_we, full, almost_full, overflow
  );

  modport slave (
    input  w_en, clr_ovf, r_ptr_ext,
    output w_ptr_ext, w_pointer, mem_we, full, almost_full, overflow
  );

endinterface

// File: rtl/fifo_ptr_cnt.sv
// Wrap-bit-extended binary pointer counter; shared by the FIFO write and read sides.
module fifo_ptr_cnt #(
  parameter int SIZE = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  output logic [SIZE:0] cnt
);

  logic [SIZE:0] cnt_q;
  logic [SIZE:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc) cnt_d = cnt_q + {{SIZE{1'b0}}, 1'b1};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/fifo_write_ctrl.sv
// FIFO write-side controller: write pointer, RAM write strobe, full / almost-full flags, sticky overflow.
module fifo_write_ctrl
  import fifo_pkg::*;
#(
  parameter int AF_LEVEL = 14
) (
  input  logic          clk,
  input  logic          rst,
  fifo_write_ctrl_if.slave bus
);

  localparam ptr_t AF_THRESH = ptr_t'(AF_LEVEL);

  ptr_t w_ptr;
  ptr_t w_ptr_post;
  logic full;
  logic w_inc;
  logic almost_full_q, almost_full_d;
  logic overflow_q, overflow_d;

  fifo_ptr_cnt #(.SIZE(SIZE)) u_w_ptr (
    .clk (clk),
    .rst (rst),
    .inc (w_inc),
    .cnt (w_ptr)
  );

  // Held low during reset so the producer sees an accepting FIFO immediately.
  assign full  = is_full(w_ptr, bus.r_ptr_ext) && !rst;
  assign w_inc = bus.w_en && !full;

  always_comb begin
    w_ptr_post    = w_inc ? w_ptr + ptr_t'(1) : w_ptr;
    // Uses the pre-edge read pointer, so a same-cycle read is only seen next cycle.
    almost_full_d = occupancy(w_ptr_post, bus.r_ptr_ext) >= AF_THRESH;
    overflow_d    = (bus.w_en && full) || (overflow_q && !bus.clr_ovf);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      almost_full_q <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      almost_full_q <= almost_full_d;
      overflow_q    <= overflow_d;
    end
  end

  assign bus.w_ptr_ext   = w_ptr;
  assign bus.w_pointer   = w_ptr[SIZE-1:0];
  assign bus.mem_we      = w_inc;
  assign bus.full        = full;
  assign bus.almost_full = almost_full_q;
  assign bus.overflow    = overflow_q;

endmodule
